data_interconnect: RTL and testbench
====================================

DATA_INTERCONNECT -- requirements
Module: data_interconnect

Interface
REQ-001 Parameter NSLAVES, default 4: number of slave ports (1..8).
REQ-002 Parameter SLV_BASE [NSLAVES*32], default {0x0000_4010, 0x0000_4000, 0x0000_2000, 0x0000_0000} (slave 3..0): region base addresses.
REQ-003 Parameter SLV_MASK [NSLAVES*32], default {0xFFFF_FFFC, 0xFFFF_FFF0, 0xFFFF_E000, 0xFFFF_E000}: region compare masks.
REQ-004 Parameter SLV_RO [NSLAVES], default 4'b0001: 1 = read-only region.
REQ-005 Parameter SLV_WAIT [NSLAVES*4], default {4'd0, 4'd2, 4'd0, 4'd0}: extra wait cycles per slave, 0..15.
REQ-006 clk_i  in  1  clock; all logic on rising edge.
REQ-007 reset_i  in  1  asynchronous, active-low reset.
REQ-008 core_req_i  in  1  request valid from core.
REQ-009 core_gnt_o  out  1  request accepted this cycle.
REQ-010 core_addr_i  in  32  byte address.
REQ-011 core_wen_i  in  1  write enable, active-low.
REQ-012 core_wdata_i  in  32  write data.
REQ-013 core_wmask_i  in  4  byte write mask.
REQ-014 core_rvalid_o  out  1  one-cycle response pulse.
REQ-015 core_rdata_o  out  32  read data, valid with rvalid.
REQ-016 core_err_o  out  1  error, valid with rvalid.
REQ-017 slv_csb_o  out  NSLAVES  per-slave chip select, active-low.
REQ-018 slv_wen_o, slv_addr_o, slv_wdata_o, slv_wmask_o  out  1/32/32/4  shared registered request fields; wen active-low.
REQ-019 slv_rdata_i  in  NSLAVES*32  per-slave read data, slave i at [32i+31:32i].

Function
REQ-020 Decode: slave i matches when (core_addr_i & SLV_MASK[i]) == SLV_BASE[i]; lowest matching index wins.
REQ-021 FSM states IDLE, ACCESS, WAIT, RESP, ERR; core_gnt_o = 1 only in IDLE.
REQ-022 Accept at cycle T when core_req_i & core_gnt_o; capture addr, wen, wdata, wmask, selected index, wait count.
REQ-023 Unmapped address, or write (wen=0) to SLV_RO slave: IDLE->ERR; no csb asserted; at T+1 rvalid=1, err=1, rdata=0; ERR->IDLE.
REQ-024 Legal access: IDLE->ACCESS; at T+1 slv_csb_o[sel]=0 for exactly one cycle, slave fields driven from captured request.
REQ-025 ACCESS->RESP if wait=0, else ->WAIT; WAIT holds wait cycles (down-counter, 4 bits, load = SLV_WAIT[sel]), then ->RESP.
REQ-026 RESP at T+2+wait: rvalid=1, err=0, rdata=slv_rdata_i[sel] for reads, 0 for writes; RESP->IDLE.
REQ-027 One outstanding transaction; next accept no earlier than cycle after RESP/ERR.
REQ-028 Outside ACCESS all slv_csb_o=1 and slv_wen_o=1; rvalid=0 outside RESP/ERR.
REQ-029 core_req_i outside IDLE is ignored (not queued).

Reset
REQ-030 reset_i low: state=IDLE, counter=0, captured regs=0, slv_csb_o all 1, slv_wen_o=1, core_rvalid_o=0, core_err_o=0, core_rdata_o=0, immediately and asynchronously.
REQ-031 Reset mid-transaction aborts it; no response is ever issued for it.
REQ-032 core_gnt_o=0 while reset_i is low.

Structure
REQ-033 Shared package bus_pkg holds FSM state encodings, default region map constants and WAIT_W=4.
REQ-034 One sub-module addr_decoder (combinational match + priority encode, outputs hit, index, ro, wait).

Verification
REQ-035 Read 0x0000_0100 (slave 0) at T -> csb[0]=0 at T+1, rvalid at T+2 with rdata=slv_rdata_i[31:0].
REQ-036 Write 0x0000_0004, wen=0 (RO slave 0) -> no csb low, rvalid=1, err=1 at T+1.
REQ-037 Read 0x0000_4008 (slave 2, wait 2) -> csb[2]=0 at T+1, gnt=0 T+1..T+4, rvalid at T+4.
REQ-038 Read 0x0001_0000 (unmapped) -> err=1 at T+1; back-to-back write 0x0000_2010 data 0xDEADBEEF wmask 4'hF -> csb[1]=0, wen=0, wdata 0xDEADBEEF, err=0.
REQ-039 reset_i low during WAIT of slave-2 read -> outputs at reset values same cycle; no rvalid after release; next request served normally.
REQ-040 Overlap test: NSLAVES=2, both base 0x0, mask 0xFFFF_0000 -> address 0x10 selects slave 0 only.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default region map for the data interconnect.
// Holds FSM state encoding, captured request bundle and wait width.
package bus_pkg;

  localparam int WAIT_W = 4;

  localparam logic [127:0] DEF_BASE = {
    32'h0000_4010, 32'h0000_4000,
    32'h0000_2000, 32'h0000_0000
  };

  localparam logic [127:0] DEF_MASK = {
    32'hFFFF_FFFC, 32'hFFFF_FFF0,
    32'hFFFF_E000, 32'hFFFF_E000
  };

  localparam logic [3:0] DEF_RO = 4'b0001;

  localparam logic [15:0] DEF_WAIT = {
    4'd0, 4'd2, 4'd0, 4'd0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

endpackage

// File: rtl/addr_decoder.sv
// Region decoder: mask/compare per slave, lowest index wins.
// In: addr. Out: hit, idx, ro (read-only region), wait_cyc.
module addr_decoder
  import bus_pkg::*;
#(
  parameter int                    NSLAVES  = 4,
  parameter int                    IDX_W    = 2,
  parameter logic [NSLAVES*32-1:0] SLV_BASE = DEF_BASE,
  parameter logic [NSLAVES*32-1:0] SLV_MASK = DEF_MASK,
  parameter logic [NSLAVES-1:0]    SLV_RO   = DEF_RO,
  parameter logic [NSLAVES*4-1:0]  SLV_WAIT = DEF_WAIT
) (
  input  logic [31:0]       addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              ro,
  output logic [WAIT_W-1:0] wait_cyc
);

  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    ro       = 1'b0;
    wait_cyc = '0;
    // Scan high to low so the lowest match overwrites last.
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32])
          == SLV_BASE[32*i +: 32]) begin
        hit      = 1'b1;
        idx      = IDX_W'(i);
        ro       = SLV_RO[i];
        wait_cyc = SLV_WAIT[WAIT_W*i +: WAIT_W];
      end
    end
  end

endmodule

// File: rtl/data_interconnect.sv
// Single-outstanding core-to-slave interconnect with wait states.
// Core req/gnt/rvalid port in, NSLAVES chip-selected slaves out.
module data_interconnect
  import bus_pkg::*;
#(
  parameter int                    NSLAVES  = 4,
  parameter logic [NSLAVES*32-1:0] SLV_BASE = DEF_BASE,
  parameter logic [NSLAVES*32-1:0] SLV_MASK = DEF_MASK,
  parameter logic [NSLAVES-1:0]    SLV_RO   = DEF_RO,
  parameter logic [NSLAVES*4-1:0]  SLV_WAIT = DEF_WAIT
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    core_req_i,
  output logic                    core_gnt_o,
  input  logic [31:0]             core_addr_i,
  input  logic                    core_wen_i,
  input  logic [31:0]             core_wdata_i,
  input  logic [3:0]              core_wmask_i,
  output logic                    core_rvalid_o,
  output logic [31:0]             core_rdata_o,
  output logic                    core_err_o,
  output logic [NSLAVES-1:0]      slv_csb_o,
  output logic                    slv_wen_o,
  output logic [31:0]             slv_addr_o,
  output logic [31:0]             slv_wdata_o,
  output logic [3:0]              slv_wmask_o,
  input  logic [NSLAVES*32-1:0]   slv_rdata_i
);

  localparam int IDX_W =
    (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  state_e            state_q;
  state_e            state_d;
  req_t              req_q;
  logic [IDX_W-1:0]  sel_q;
  logic [WAIT_W-1:0] cnt_q;

  logic              dec_hit;
  logic              dec_ro;
  logic [IDX_W-1:0]  dec_idx;
  logic [WAIT_W-1:0] dec_wait;
  logic              accept;
  logic              bad;
  logic [31:0]       rdata_arr [NSLAVES];

  addr_decoder #(
    .NSLAVES  (NSLAVES),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .SLV_RO   (SLV_RO),
    .SLV_WAIT (SLV_WAIT)
  ) u_dec (
    .addr     (core_addr_i),
    .hit      (dec_hit),
    .idx      (dec_idx),
    .ro       (dec_ro),
    .wait_cyc (dec_wait)
  );

  // Grant is masked by reset so nothing is accepted while held.
  assign core_gnt_o = reset_i && (state_q == ST_IDLE);
  assign accept     = core_req_i && core_gnt_o;
  assign bad        = !dec_hit || (dec_ro && !core_wen_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = bad ? ST_ERR : ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = (cnt_q == '0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.addr  <= core_addr_i;
        req_q.wen   <= core_wen_i;
        req_q.wdata <= core_wdata_i;
        req_q.wmask <= core_wmask_i;
        sel_q       <= dec_idx;
        cnt_q       <= dec_wait;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - WAIT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSLAVES; i++) begin
      rdata_arr[i] = slv_rdata_i[32*i +: 32];
    end
  end

  always_comb begin
    slv_csb_o = '1;
    if (state_q == ST_ACCESS) slv_csb_o[sel_q] = 1'b0;
  end

  assign slv_wen_o   = (state_q == ST_ACCESS) ? req_q.wen : 1'b1;
  assign slv_addr_o  = req_q.addr;
  assign slv_wdata_o = req_q.wdata;
  assign slv_wmask_o = req_q.wmask;

  assign core_rvalid_o = (state_q == ST_RESP)
                      || (state_q == ST_ERR);
  assign core_err_o    = (state_q == ST_ERR);
  // Writes return zero data; only reads forward the slave word.
  assign core_rdata_o  = (state_q == ST_RESP && req_q.wen)
                         ? rdata_arr[sel_q] : '0;

endmodule

// File: tb/tb_data_interconnect.sv
// Scoreboard bench for data_interconnect plus an overlap instance.
// Responses are queued at issue and popped on core_rvalid_o.
module tb_data_interconnect;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_gnt_o;
  logic [31:0] core_addr_i = '0;
  logic        core_wen_i = 1'b1;
  logic [31:0] core_wdata_i = '0;
  logic [3:0]  core_wmask_i = '0;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic [3:0]  slv_csb_o;
  logic        slv_wen_o;
  logic [31:0] slv_addr_o;
  logic [31:0] slv_wdata_o;
  logic [3:0]  slv_wmask_o;
  logic [127:0] slv_rdata_i;

  logic        req2 = 1'b0;
  logic        gnt2;
  logic [31:0] addr2 = '0;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        err2;
  logic [1:0]  csb2;
  logic        wen2o;
  logic [31:0] addr2o;
  logic [31:0] wdata2o;
  logic [3:0]  wmask2o;
  logic [63:0] rd2 = {32'h2222_2222, 32'h1111_1111};

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] sb_q [$];

  always #5 clk_i = ~clk_i;

  // Slave model: word carries slave id and low address bits.
  function automatic logic [31:0] model_rd(
    input int s, input logic [31:0] a);
    logic [3:0] id;
    id = 4'(s);
    return {id, 4'hA, a[23:0]};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++)
      slv_rdata_i[32*i +: 32] = model_rd(i, slv_addr_o);
  end

  data_interconnect u_dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .core_req_i    (core_req_i),
    .core_gnt_o    (core_gnt_o),
    .core_addr_i   (core_addr_i),
    .core_wen_i    (core_wen_i),
    .core_wdata_i  (core_wdata_i),
    .core_wmask_i  (core_wmask_i),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .core_err_o    (core_err_o),
    .slv_csb_o     (slv_csb_o),
    .slv_wen_o     (slv_wen_o),
    .slv_addr_o    (slv_addr_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_wmask_o   (slv_wmask_o),
    .slv_rdata_i   (slv_rdata_i)
  );

  data_interconnect #(
    .NSLAVES  (2),
    .SLV_BASE (64'h0),
    .SLV_MASK ({2{32'hFFFF_0000}}),
    .SLV_RO   (2'b00),
    .SLV_WAIT (8'h00)
  ) u_dut2 (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .core_req_i    (req2),
    .core_gnt_o    (gnt2),
    .core_addr_i   (addr2),
    .core_wen_i    (1'b1),
    .core_wdata_i  (32'h0),
    .core_wmask_i  (4'h0),
    .core_rvalid_o (rvalid2),
    .core_rdata_o  (rdata2),
    .core_err_o    (err2),
    .slv_csb_o     (csb2),
    .slv_wen_o     (wen2o),
    .slv_addr_o    (addr2o),
    .slv_wdata_o   (wdata2o),
    .slv_wmask_o   (wmask2o),
    .slv_rdata_i   (rd2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (core_rvalid_o) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rvalid", 1, 0);
      end else begin
        chk("resp", {core_err_o, core_rdata_o},
            sb_q.pop_front());
      end
    end
  end

  task automatic do_req(input logic [31:0] a,
                        input logic w,
                        input logic [31:0] d,
                        input logic [3:0] m,
                        input int sel,
                        input logic err,
                        input int wt,
                        input bit hold);
    logic [31:0] er;
    logic [3:0]  ecsb;
    int n;
    int lat;
    @(negedge clk_i);
    n = 0;
    while (!core_gnt_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("gnt_idle", core_gnt_o, 1);
    core_req_i   = 1'b1;
    core_addr_i  = a;
    core_wen_i   = w;
    core_wdata_i = d;
    core_wmask_i = m;
    er = (err || !w) ? 32'h0 : model_rd(sel, a);
    sb_q.push_back({err, er});
    @(negedge clk_i);
    if (!hold) core_req_i = 1'b0;
    chk("gnt_busy", core_gnt_o, 0);
    ecsb = 4'hF;
    if (!err) ecsb[sel] = 1'b0;
    chk("csb", slv_csb_o, ecsb);
    if (!err) begin
      chk("slv_wen", slv_wen_o, w);
      chk("slv_addr", slv_addr_o, a);
      if (!w) begin
        chk("slv_wdata", slv_wdata_o, d);
        chk("slv_wmask", slv_wmask_o, m);
      end
    end
    lat = 1;
    while (!core_rvalid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
      chk("csb_idle", slv_csb_o, 4'hF);
      chk("gnt_wait", core_gnt_o, 0);
    end
    chk("latency", lat, err ? 1 : 2 + wt);
    core_req_i = 1'b0;
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", core_gnt_o, 0);
    chk("rst_csb", slv_csb_o, 4'hF);
    chk("rst_wen", slv_wen_o, 1);
    chk("rst_rvalid", core_rvalid_o, 0);
    chk("rst_err", core_err_o, 0);
    chk("rst_rdata", core_rdata_o, 0);
    reset_i = 1'b1;

    do_req(32'h0000_0100, 1, 0, 0, 0, 0, 0, 0);
    do_req(32'h0000_0004, 0, 32'h55, 4'hF, 0, 1, 0, 0);
    do_req(32'h0000_4008, 1, 0, 0, 2, 0, 2, 0);
    do_req(32'h0001_0000, 1, 0, 0, 0, 1, 0, 0);
    do_req(32'h0000_2010, 0, 32'hDEAD_BEEF, 4'hF,
           1, 0, 0, 0);
    do_req(32'h0000_4010, 1, 0, 0, 3, 0, 0, 1);
    do_req(32'h0000_4004, 0, 32'h1234_5678, 4'h5,
           2, 0, 2, 0);
    do_req(32'h0000_1FFC, 1, 0, 0, 0, 0, 0, 0);

    // Abort a slave-2 read inside its wait window.
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_addr_i = 32'h0000_4008;
    core_wen_i  = 1'b1;
    @(negedge clk_i);
    core_req_i = 1'b0;
    chk("abort_csb", slv_csb_o, 4'b1011);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("abort_csb_rst", slv_csb_o, 4'hF);
    chk("abort_wen_rst", slv_wen_o, 1);
    chk("abort_gnt_rst", core_gnt_o, 0);
    chk("abort_rv_rst", core_rvalid_o, 0);
    chk("abort_err_rst", core_err_o, 0);
    chk("abort_rd_rst", core_rdata_o, 0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (core_rvalid_o) pulses++;
    end
    chk("abort_no_resp", pulses, 0);
    do_req(32'h0000_4000, 1, 0, 0, 2, 0, 2, 0);

    // Overlapping regions: lowest index must win.
    @(negedge clk_i);
    chk("ovl_gnt", gnt2, 1);
    req2  = 1'b1;
    addr2 = 32'h0000_0010;
    @(negedge clk_i);
    req2 = 1'b0;
    chk("ovl_csb", csb2, 2'b10);
    @(negedge clk_i);
    chk("ovl_rvalid", rvalid2, 1);
    chk("ovl_rdata", rdata2, 32'h1111_1111);
    chk("ovl_err", err2, 0);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
